// File: rtl/x_delay_scan_ctrl.sv
// rtl/x_delay_scan_ctrl.sv - per-channel delay registers with automatic best-delay scan
// A scan sweeps one channel through every delay setting, counts probe hits, and applies the winner.
module x_delay_scan_ctrl #(
  parameter int MXDLY = 4,
  parameter int NCH   = 8,
  parameter int MXCH  = 3,
  parameter int MXCNT = 12
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [MXCH-1:0]      wr_ch,
  input  logic [MXDLY-1:0]     wr_dly,
  input  logic                 scan_start,
  input  logic [MXCH-1:0]      scan_ch,
  input  logic [MXCNT-1:0]     dwell,
  input  logic                 probe,
  output logic [NCH*MXDLY-1:0] delay_bus,
  output logic                 scan_busy,
  output logic                 scan_done,
  output logic [MXDLY-1:0]     best_dly,
  output logic [MXCNT-1:0]     best_cnt,
  output logic                 wr_reject
);

  localparam int MXSR = 1 << MXDLY;
  // Timer must hold both the settle length (MXSR) and the longest dwell.
  localparam int TW = (MXCNT > MXDLY + 1) ? MXCNT : MXDLY + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SET, S_SETTLE, S_DWELL, S_NEXT, S_APPLY, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [MXCH-1:0]   sch;
  logic [MXCNT-1:0]  sdwell;
  logic [MXDLY-1:0]  step;
  logic [MXCNT-1:0]  hits;
  logic [TW-1:0]     tmr;
  logic [MXDLY-1:0]  dly [NCH];

  logic accept, scan_ch_ok, wr_ch_ok, wr_bad, wr_ok, start_bad;

  assign scan_busy  = (state != S_IDLE) && (state != S_DONE);
  assign scan_done  = (state == S_DONE);
  assign scan_ch_ok = int'(scan_ch) < NCH;
  assign wr_ch_ok   = int'(wr_ch) < NCH;
  assign wr_bad     = wr_en && (!wr_ch_ok || (scan_busy && (wr_ch == sch)));
  assign wr_ok      = wr_en && !wr_bad;
  assign start_bad  = (state == S_IDLE) && scan_start && !scan_ch_ok;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (scan_start && scan_ch_ok) begin
          accept    = 1'b1;
          state_nxt = S_SET;
        end
      end
      S_SET:    state_nxt = S_SETTLE;
      S_SETTLE: if (tmr == TW'(MXSR - 1)) state_nxt = S_DWELL;
      S_DWELL:  if (tmr == TW'(sdwell) - TW'(1)) state_nxt = S_NEXT;
      S_NEXT:   state_nxt = (&step) ? S_APPLY : S_SET;
      S_APPLY:  state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      sch       <= '0;
      sdwell    <= '0;
      step      <= '0;
      hits      <= '0;
      tmr       <= '0;
      best_dly  <= '0;
      best_cnt  <= '0;
      wr_reject <= 1'b0;
      for (int k = 0; k < NCH; k++) dly[k] <= '0;
    end else begin
      state     <= state_nxt;
      tmr       <= (state_nxt != state) ? '0 : tmr + TW'(1);
      wr_reject <= wr_bad || start_bad;

      if (accept) begin
        sch      <= scan_ch;
        sdwell   <= (dwell == '0) ? MXCNT'(1) : dwell;
        best_dly <= '0;
        best_cnt <= '0;
        step     <= '0;
      end

      // Hit counter saturates rather than wrapping.
      if (state == S_SET) hits <= '0;
      else if (state == S_DWELL && probe && !(&hits)) hits <= hits + MXCNT'(1);

      // Strict greater-than keeps the lowest delay on ties.
      if (state == S_NEXT) begin
        if (hits > best_cnt) begin
          best_cnt <= hits;
          best_dly <= step;
        end
        if (!(&step)) step <= step + MXDLY'(1);
      end

      for (int k = 0; k < NCH; k++) begin
        if (wr_ok && int'(wr_ch) == k) dly[k] <= wr_dly;
        if (int'(sch) == k && state == S_SET) dly[k] <= step;
        if (int'(sch) == k && state == S_APPLY) dly[k] <= best_dly;
      end
    end
  end

  always_comb begin
    delay_bus = '0;
    for (int k = 0; k < NCH; k++) delay_bus[k*MXDLY +: MXDLY] = dly[k];
  end

endmodule

// File: tb/tb_x_delay_scan_ctrl.sv
// tb/tb_x_delay_scan_ctrl.sv - directed bench with timeline model of the delay scan controller
module tb_x_delay_scan_ctrl;

  localparam int NC   = 8;
  localparam int MXSR = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [3:0]  wr_ch;
  logic [3:0]  wr_dly;
  logic        scan_start;
  logic [3:0]  scan_ch;
  logic [11:0] dwell;
  logic        probe;
  logic [31:0] delay_bus;
  logic        scan_busy, scan_done, wr_reject;
  logic [3:0]  best_dly;
  logic [11:0] best_cnt;

  logic        scan_start2;
  logic        probe2;
  logic [3:0]  delay_bus2;
  logic        scan_busy2, scan_done2, wr_reject2;
  logic [3:0]  best_dly2;
  logic [3:0]  best_cnt2;

  int pmode = 0;
  logic [3:0] f2;
  assign f2 = delay_bus[11:8];
  assign probe = (pmode == 1) ? (f2 == 4'd9) :
                 (pmode == 2) ? 1'b1 :
                 (pmode == 3) ? (f2 == 4'd4 || f2 == 4'd11) : 1'b0;

  x_delay_scan_ctrl #(.MXDLY(4), .NCH(8), .MXCH(4), .MXCNT(12)) dut (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_dly(wr_dly),
    .scan_start(scan_start), .scan_ch(scan_ch), .dwell(dwell), .probe(probe),
    .delay_bus(delay_bus), .scan_busy(scan_busy), .scan_done(scan_done),
    .best_dly(best_dly), .best_cnt(best_cnt), .wr_reject(wr_reject)
  );

  x_delay_scan_ctrl #(.MXDLY(4), .NCH(1), .MXCH(1), .MXCNT(4)) dut_sat (
    .clock(clock), .reset_n(reset_n), .wr_en(1'b0), .wr_ch(1'b0), .wr_dly(4'd0),
    .scan_start(scan_start2), .scan_ch(1'b0), .dwell(4'd15), .probe(probe2),
    .delay_bus(delay_bus2), .scan_busy(scan_busy2), .scan_done(scan_done2),
    .best_dly(best_dly2), .best_cnt(best_cnt2), .wr_reject(wr_reject2)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int rej_seen = 0;
  int done_seen = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Model: a scan is a timeline of cycles indexed from SET(0); step length L = MXSR + D + 2.
  int ph = -1;
  int mch = 0, md = 1, ml = 19;
  int mcnt = 0, mbcnt = 0, mbdly = 0;
  int st, w;
  bit mrej = 0;
  bit busy_e;
  logic [3:0] mdly [NC];

  always @(posedge clock) begin
    cyc++;
    if (!reset_n) begin
      ph = -1; mcnt = 0; mbcnt = 0; mbdly = 0; mrej = 0;
      for (int i = 0; i < NC; i++) mdly[i] = 4'd0;
    end else begin
      busy_e = (ph >= 0) && (ph <= MXSR * ml);
      mrej = 0;
      if (wr_en) begin
        if (int'(wr_ch) >= NC || (busy_e && int'(wr_ch) == mch)) mrej = 1;
        else mdly[wr_ch] = wr_dly;
      end
      if (ph >= 0) begin
        st = ph / ml;
        w  = ph % ml;
        if (ph < MXSR * ml) begin
          if (w == 0) begin
            mdly[mch] = 4'(st);
            mcnt = 0;
          end else if (w > MXSR && w <= MXSR + md) begin
            if (probe && mcnt < 4095) mcnt++;
          end else if (w == ml - 1) begin
            if (mcnt > mbcnt) begin
              mbcnt = mcnt;
              mbdly = st;
            end
          end
        end else if (ph == MXSR * ml) begin
          mdly[mch] = 4'(mbdly);
        end
        ph = (ph == MXSR * ml + 1) ? -1 : ph + 1;
      end else if (scan_start) begin
        if (int'(scan_ch) < NC) begin
          ph = 0; mch = int'(scan_ch);
          md = (dwell == 0) ? 1 : int'(dwell);
          ml = MXSR + md + 2;
          mbcnt = 0; mbdly = 0; mcnt = 0;
        end else begin
          mrej = 1;
        end
      end
    end
  end

  logic [31:0] exp_bus;
  always @(negedge clock) begin
    if (wr_reject) rej_seen++;
    if (scan_done) done_seen++;
    if (chk_en) begin
      exp_bus = '0;
      for (int i = 0; i < NC; i++) exp_bus[i*4 +: 4] = mdly[i];
      check("delay_bus", delay_bus, exp_bus);
      check("scan_busy", 32'(scan_busy), 32'((ph >= 0) && (ph <= MXSR * ml)));
      check("scan_done", 32'(scan_done), 32'(ph == MXSR * ml + 1));
      check("best_dly", 32'(best_dly), 32'(mbdly));
      check("best_cnt", 32'(best_cnt), 32'(mbcnt));
      check("wr_reject", 32'(wr_reject), 32'(mrej));
    end
  end

  task automatic host_write(input int ch, input int d);
    @(negedge clock);
    wr_en = 1'b1; wr_ch = 4'(ch); wr_dly = 4'(d);
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic start_scan(input int ch, input int dw, output int a);
    @(negedge clock);
    scan_start = 1'b1; scan_ch = 4'(ch); dwell = 12'(dw);
    a = cyc;
    @(negedge clock);
    scan_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int limit, output int c);
    int n;
    n = 0;
    c = -1;
    while (n < limit && c < 0) begin
      @(negedge clock);
      if (scan_done) c = cyc;
      n++;
    end
    if (c < 0) begin
      vectors++;
      errors++;
      $display("FAIL %s timeout: actual=no scan_done required=scan_done within %0d cycles", nm, limit);
    end
  endtask

  int a, dc, n, d0;

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_dly = '0;
    scan_start = 1'b0; scan_ch = '0; dwell = '0;
    scan_start2 = 1'b0; probe2 = 1'b0;
    repeat (3) @(negedge clock);
    chk_en = 1;
    check("reset_bus", delay_bus, 32'h0);
    check("reset_best", {best_dly, 16'h0, best_cnt}, 32'h0);
    reset_n = 1'b1;

    host_write(0, 3);
    host_write(7, 15);
    host_write(8, 5);
    repeat (2) @(negedge clock);
    check("write_bus", delay_bus, 32'hF000_0003);
    check("write_rej_count", 32'(rej_seen), 32'd1);

    pmode = 1;
    start_scan(2, 10, a);
    wait_done("scan_peak", 600, dc);
    check("peak_done_latency", 32'(dc - a), 32'd450);
    check("peak_best_dly", 32'(best_dly), 32'd9);
    check("peak_best_cnt", 32'(best_cnt), 32'd10);
    check("peak_bus", delay_bus, 32'hF000_0903);

    pmode = 3;
    start_scan(2, 5, a);
    repeat (40) @(negedge clock);
    host_write(2, 7);
    host_write(5, 6);
    start_scan(5, 3, n);
    wait_done("scan_tie", 600, dc);
    check("tie_best_dly", 32'(best_dly), 32'd4);
    check("tie_best_cnt", 32'(best_cnt), 32'd5);
    check("tie_bus", delay_bus, 32'hF060_0403);
    check("tie_rej_count", 32'(rej_seen), 32'd2);
    @(negedge clock);
    start_scan(9, 4, n);
    repeat (2) @(negedge clock);
    check("badch_rej_count", 32'(rej_seen), 32'd3);
    check("badch_busy", 32'(scan_busy), 32'd0);

    pmode = 0;
    d0 = done_seen;
    start_scan(3, 2, a);
    n = 0;
    while (ph != 5 * 20 + 3 && n < 300) begin
      @(negedge clock);
      n++;
    end
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("midreset_bus", delay_bus, 32'h0);
    check("midreset_busy", 32'(scan_busy), 32'd0);
    repeat (3) @(negedge clock);
    check("midreset_no_done", 32'(done_seen), 32'(d0));

    pmode = 2;
    start_scan(1, 0, a);
    wait_done("scan_dwell0", 600, dc);
    check("dwell0_latency", 32'(dc - a), 32'd306);
    check("dwell0_best_dly", 32'(best_dly), 32'd0);
    check("dwell0_best_cnt", 32'(best_cnt), 32'd1);
    pmode = 0;

    probe2 = 1'b1;
    @(negedge clock);
    scan_start2 = 1'b1;
    @(negedge clock);
    scan_start2 = 1'b0;
    n = 0;
    while (!scan_done2 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("sat_done_seen", 32'(scan_done2), 32'd1);
    check("sat_best_cnt", 32'(best_cnt2), 32'd15);
    check("sat_best_dly", 32'(best_dly2), 32'd0);
    check("sat_bus", 32'(delay_bus2), 32'd0);
    check("sat_rej", 32'(wr_reject2), 32'd0);

    repeat (2) @(negedge clock);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1);
  end

endmodule
